// File: rtl/runge_kutta_pkg.sv
// Shared types and constants for the RK4 dy/dt = -y solver.
package runge_kutta_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    K1   = 3'd1,
    K2   = 3'd2,
    K3   = 3'd3,
    K4   = 3'd4,
    UPD  = 3'd5,
    DONE = 3'd6
  } rk_state_t;

  typedef logic signed [31:0] fix_t;

  // round(2^30 / 6); pairs with the default 30 fractional bits
  localparam fix_t        ONE_SIXTH = 32'sd178956971;
  localparam fix_t        Y0_FIX    = 32'sd1073741824;
  localparam logic [63:0] DBL_ONE   = 64'h3FF0_0000_0000_0000;

endpackage

// File: rtl/runge_kutta_fix2double.sv
// Combinational signed fixed-point to IEEE-754 binary64 converter.
// Every 32-bit value is exactly representable, so no rounding stage is needed.
module fix2double
  import runge_kutta_pkg::*;
#(
  parameter int FRAC = 30
) (
  input  fix_t        x,
  output logic [63:0] d
);

  logic [31:0] mag_s;
  logic [4:0]  msb_s;
  logic [10:0] exp_s;
  logic [63:0] sh_s;

  // magnitude, leading-one position, then left-align the bits below it
  always_comb begin
    mag_s = x[31] ? (32'd0 - 32'(x)) : 32'(x);
    msb_s = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (mag_s[i]) begin
        msb_s = 5'(i);
      end else begin
        msb_s = msb_s;
      end
    end
    exp_s = 11'd1023 + {6'd0, msb_s} - 11'(FRAC);
    sh_s  = {32'd0, mag_s} << (6'd52 - {1'b0, msb_s});
    if (mag_s == 32'd0) begin
      d = 64'd0;
    end else begin
      d = {x[31], exp_s, sh_s[51:0]};
    end
  end

endmodule

// File: rtl/runge_kutta.sv
// Fixed-step RK4 solver for dy/dt = -y, y(0) = 1.0; each step exported as binary64.
// Optional macro RK_STATUS_EN adds registered busy/done status outputs.
module runge_kutta
  import runge_kutta_pkg::*;
#(
  parameter int N_STEPS = 8,
  parameter int H_SHIFT = 3,
  parameter int FRAC    = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [63:0] GERVACIO
`ifdef RK_STATUS_EN
  ,
  output logic        busy,
  output logic        done
`endif
);

  rk_state_t          state_r, state_s;
  fix_t               y_r, y_s;
  fix_t               k1_r, k1_s, k2_r, k2_s, k3_r, k3_s, k4_r, k4_s;
  logic [7:0]         step_cnt_r, step_cnt_s;
  logic [63:0]        dbl_r, dbl_s;
  fix_t               sum_s, y_upd_s;
  logic signed [63:0] prod_s;
  logic [63:0]        conv_s;

  fix2double #(.FRAC(FRAC)) u_conv (
    .x (y_upd_s),
    .d (conv_s)
  );

  // next-state and datapath; the converter sees the candidate updated y
  always_comb begin
    state_s    = state_r;
    y_s        = y_r;
    k1_s       = k1_r;
    k2_s       = k2_r;
    k3_s       = k3_r;
    k4_s       = k4_r;
    step_cnt_s = step_cnt_r;
    dbl_s      = dbl_r;
    sum_s      = k1_r + (k2_r <<< 1) + (k3_r <<< 1) + k4_r;
    prod_s     = {{32{sum_s[31]}}, sum_s} * {32'd0, ONE_SIXTH};
    y_upd_s    = y_r + fix_t'(prod_s >>> FRAC);
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          y_s        = Y0_FIX;
          step_cnt_s = 8'd0;
          dbl_s      = DBL_ONE;
          state_s    = K1;
        end else begin
          state_s    = state_r;
        end
      end
      K1: begin
        k1_s    = -(y_r >>> H_SHIFT);
        state_s = K2;
      end
      K2: begin
        k2_s    = -((y_r + (k1_r >>> 1)) >>> H_SHIFT);
        state_s = K3;
      end
      K3: begin
        k3_s    = -((y_r + (k2_r >>> 1)) >>> H_SHIFT);
        state_s = K4;
      end
      K4: begin
        k4_s    = -((y_r + k3_r) >>> H_SHIFT);
        state_s = UPD;
      end
      UPD: begin
        y_s        = y_upd_s;
        dbl_s      = conv_s;
        step_cnt_s = step_cnt_r + 8'd1;
        if (step_cnt_r == 8'(N_STEPS - 1)) begin
          state_s = DONE;
        end else begin
          state_s = K1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      y_r        <= 32'sd0;
      k1_r       <= 32'sd0;
      k2_r       <= 32'sd0;
      k3_r       <= 32'sd0;
      k4_r       <= 32'sd0;
      step_cnt_r <= 8'd0;
      dbl_r      <= 64'd0;
    end else begin
      state_r    <= state_s;
      y_r        <= y_s;
      k1_r       <= k1_s;
      k2_r       <= k2_s;
      k3_r       <= k3_s;
      k4_r       <= k4_s;
      step_cnt_r <= step_cnt_s;
      dbl_r      <= dbl_s;
    end
  end

  assign GERVACIO = dbl_r;

`ifdef RK_STATUS_EN
  logic busy_r, done_r;

  // status flags registered from the next state so they align with state_r
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_s == K1) || (state_s == K2) || (state_s == K3) ||
                (state_s == K4) || (state_s == UPD);
      done_r <= (state_s == DONE);
    end
  end

  assign busy = busy_r;
  assign done = done_r;
`endif

endmodule

// File: tb/tb_runge_kutta.sv
// Self-checking bench for runge_kutta: real-valued RK4 reference via a scoreboard queue.
module tb_runge_kutta;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [63:0] gervacio;
`ifdef RK_STATUS_EN
  logic        busy, done;
`endif

  logic signed [31:0] cx = 32'sd0;
  logic [63:0]        cd;

  int  errors = 0;
  int  checks = 0;
  real exp_q[$];
  real g;
  localparam real H   = 0.125;
  localparam real TOL = 1.0e-6;

  runge_kutta dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .GERVACIO (gervacio)
`ifdef RK_STATUS_EN
    ,
    .busy     (busy),
    .done     (done)
`endif
  );

  fix2double #(.FRAC(30)) u_f2d (
    .x (cx),
    .d (cd)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic real absdiff(input real a, input real b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  task automatic push_run(input int n);
    real e;
    e = 1.0;
    for (int i = 0; i <= n; i++) begin
      exp_q.push_back(e);
      e = e * g;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    #3;
    checks++;
    if (gervacio !== 64'h0) begin
      errors++;
      $display("FAIL reset_value: got %h expected %h", gervacio, 64'h0);
    end
    tick(2);
    rst = 1'b1;
    tick(3);
    checks++;
    if (gervacio !== 64'h0) begin
      errors++;
      $display("FAIL idle_after_release: got %h expected %h", gervacio, 64'h0);
    end
`ifdef RK_STATUS_EN
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: got busy=%b done=%b expected 0 0", busy, done);
    end
`endif
  endtask

  task automatic test_single_run;
    real e, a;
    logic [63:0] last;
    push_run(8);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (gervacio !== 64'h3FF0_0000_0000_0000) begin
      errors++;
      $display("FAIL run_start_one: got %h expected %f", gervacio, e);
    end
`ifdef RK_STATUS_EN
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL run_busy: got %b expected 1", busy);
    end
`endif
    for (int s = 1; s <= 8; s++) begin
      tick(5);
      e = exp_q.pop_front();
      a = $bitstoreal(gervacio);
      checks++;
      if (absdiff(a, e) > TOL) begin
        errors++;
        $display("FAIL run_step%0d: got %f (%h) expected %f", s, a, gervacio, e);
      end
    end
    a = $bitstoreal(gervacio);
    checks++;
    if (absdiff(a, 0.3678795) > TOL) begin
      errors++;
      $display("FAIL run_final_e_inv: got %f expected 0.3678795", a);
    end
`ifdef RK_STATUS_EN
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL run_done: got busy=%b done=%b expected 0 1", busy, done);
    end
`endif
    last = gervacio;
    tick(4);
    checks++;
    if (gervacio !== last) begin
      errors++;
      $display("FAIL run_hold: got %h expected %h", gervacio, last);
    end
  endtask

  task automatic test_start_held;
    real e, a, prev;
    push_run(8);
    exp_q.push_back(1.0);
    start = 1'b1;
    tick(1);
    e = exp_q.pop_front();
    checks++;
    if (gervacio !== 64'h3FF0_0000_0000_0000) begin
      errors++;
      $display("FAIL held_start_one: got %h expected %f", gervacio, e);
    end
    prev = 1.0;
    for (int s = 1; s <= 8; s++) begin
      tick(5);
      e = exp_q.pop_front();
      a = $bitstoreal(gervacio);
      checks++;
      if (absdiff(a, e) > TOL || !(a < prev)) begin
        errors++;
        $display("FAIL held_step%0d: got %f expected %f (below %f)", s, a, e, prev);
      end
      prev = a;
    end
    tick(1);
    e = exp_q.pop_front();
    checks++;
    if (gervacio !== 64'h3FF0_0000_0000_0000) begin
      errors++;
      $display("FAIL held_restart: got %h expected %f", gervacio, e);
    end
    start = 1'b0;
    tick(45);
  endtask

  task automatic test_start_ignored;
    real e, a;
    push_run(1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (gervacio !== 64'h3FF0_0000_0000_0000) begin
      errors++;
      $display("FAIL ign_start_one: got %h expected %f", gervacio, e);
    end
    tick(1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(3);
    e = exp_q.pop_front();
    a = $bitstoreal(gervacio);
    checks++;
    if (absdiff(a, e) > 1.0e-7) begin
      errors++;
      $display("FAIL ign_step1: got %f (%h) expected %f", a, gervacio, e);
    end
    tick(40);
  endtask

  task automatic test_reset_mid_run;
    real e, a;
    push_run(1);
    exp_q.push_back(1.0);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    e = exp_q.pop_front();
    tick(5);
    e = exp_q.pop_front();
    a = $bitstoreal(gervacio);
    checks++;
    if (absdiff(a, e) > TOL) begin
      errors++;
      $display("FAIL mid_step1: got %f expected %f", a, e);
    end
    tick(2);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (gervacio !== 64'h0) begin
      errors++;
      $display("FAIL mid_reset_async: got %h expected %h", gervacio, 64'h0);
    end
`ifdef RK_STATUS_EN
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_busy: got %b expected 0", busy);
    end
`endif
    tick(2);
    rst = 1'b1;
    tick(3);
    checks++;
    if (gervacio !== 64'h0) begin
      errors++;
      $display("FAIL mid_reset_idle: got %h expected %h", gervacio, 64'h0);
    end
    start = 1'b1;
    tick(1);
    start = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (gervacio !== 64'h3FF0_0000_0000_0000) begin
      errors++;
      $display("FAIL mid_restart: got %h expected %f", gervacio, e);
    end
    tick(45);
  endtask

  task automatic test_fix2double;
    logic signed [31:0] vin [6];
    logic [63:0]        vexp [6];
    vin[0] = 32'sd0;           vexp[0] = 64'h0000_0000_0000_0000;
    vin[1] = 32'sd1073741824;  vexp[1] = 64'h3FF0_0000_0000_0000;
    vin[2] = -32'sd536870912;  vexp[2] = 64'hBFE0_0000_0000_0000;
    vin[3] = 32'sd1;           vexp[3] = 64'h3E10_0000_0000_0000;
    vin[4] = 32'h8000_0000;    vexp[4] = 64'hC000_0000_0000_0000;
    vin[5] = 32'sd1610612736;  vexp[5] = 64'h3FF8_0000_0000_0000;
    for (int i = 0; i < 6; i++) begin
      cx = vin[i];
      #1;
      checks++;
      if (cd !== vexp[i]) begin
        errors++;
        $display("FAIL f2d_%0d: in %h got %h expected %h", i, vin[i], cd, vexp[i]);
      end
    end
  endtask

  initial begin
    g = 1.0 - H + H * H / 2.0 - H * H * H / 6.0 + H * H * H * H / 24.0;
    test_reset();
    test_single_run();
    test_start_held();
    test_start_ignored();
    test_reset_mid_run();
    test_fix2double();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
